reg_writeback: RTL

//  Write-side driver for the 32x32 register file. Merges two result sources into the single
//  RF write port (write/reg_write/wdata): a fixed-latency ALU path and a variable-latency

---
 rtl/reg_writeback.sv | 98 +++++++++
 1 files changed

// File: rtl/reg_writeback.sv
// Register-file write-port driver: merges a fixed-latency ALU result with queued load results
// and tracks destinations of outstanding loads so decode can stall on them.
module reg_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int QDEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_dest,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  output logic              issue_err,
  input  logic [ADDR_W-1:0] chk_a,
  input  logic [ADDR_W-1:0] chk_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              write,
  output logic [ADDR_W-1:0] reg_write,
  output logic [DATA_W-1:0] wdata
);
  localparam int PW = $clog2(QDEPTH);
  localparam int NREG = 2 ** ADDR_W;
  localparam logic [PW:0] FULL = (PW + 1)'(QDEPTH);

  logic [QDEPTH-1:0][ADDR_W-1:0] qdest;
  logic [QDEPTH-1:0][DATA_W-1:0] qdata;
  logic [PW-1:0] wp, rp;
  logic [PW:0]   cnt;
  logic [NREG-1:0] pending, pend_clr;

  logic alu_sel, ld_sel, push, issue_ok;
  logic [ADDR_W-1:0] head_dest;

  assign head_dest = qdest[rp];
  assign ld_ready  = !rst && (cnt < FULL);
  assign push      = ld_valid && ld_ready && (ld_dest != '0);
  assign alu_sel   = alu_valid && (alu_dest != '0);
  assign ld_sel    = !alu_sel && (cnt != '0);

  // The selection-cycle clear is visible right away, both to decode and to a
  // same-cycle issue, so re-issuing a dest as its load retires is legal.
  always_comb begin
    pend_clr = pending;
    if (ld_sel) pend_clr[head_dest] = 1'b0;
  end

  assign issue_ok = issue_valid && (issue_dest != '0) && !pend_clr[issue_dest];
  assign busy_a   = (chk_a != '0) && pend_clr[chk_a];
  assign busy_b   = (chk_b != '0) && pend_clr[chk_b];

  always_ff @(posedge clk) begin
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      cnt       <= '0;
      pending   <= '0;
      issue_err <= 1'b0;
      write     <= 1'b0;
      reg_write <= '0;
      wdata     <= '0;
    end else begin
      if (push) begin
        qdest[wp] <= ld_dest;
        qdata[wp] <= ld_data;
        wp        <= wp + 1'b1;
      end
      if (ld_sel) rp <= rp + 1'b1;
      case ({push, ld_sel})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase

      pending <= pend_clr;
      if (issue_ok) pending[issue_dest] <= 1'b1;
      issue_err <= issue_valid && (issue_dest != '0) && pend_clr[issue_dest];

      write <= alu_sel || ld_sel;
      if (alu_sel) begin
        reg_write <= alu_dest;
        wdata     <= alu_data;
      end else if (ld_sel) begin
        reg_write <= head_dest;
        wdata     <= qdata[rp];
      end else begin
        reg_write <= '0;
        wdata     <= '0;
      end
    end
  end
endmodule
